sync_pulse_gen: RTL and testbench

//  Timing-pulse source for the B700 synchroniser. Generates the one-clock strobes TNO, TNC, TNI, TKI,
//  TNP, TKP and TOBM from a programmable frame/cycle schedule. These strobes feed the test-output

---
 rtl/sync_pkg.sv | 21 ++
 rtl/sync_cfg_shadow.sv | 34 +++
 rtl/sync_pulse_gen.sv | 74 +++++++
 tb/tb_sync_pulse_gen.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// sync_pkg: shared types, widths and config validation for the B700 timing-pulse source
package sync_pkg;
  localparam int CNT_W = 24;
  localparam int NCYC_W = 8;
  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [NCYC_W-1:0] ncyc;
    logic [CNT_W-1:0] ti_beg;
    logic [CNT_W-1:0] ti_end;
    logic [CNT_W-1:0] tp_beg;
    logic [CNT_W-1:0] tp_end;
    logic [CNT_W-1:0] tobm;
  } sync_cfg_t;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  function automatic logic cfg_valid(sync_cfg_t c);
    return c.period > CNT_W'(1) && c.ncyc != '0 &&
           c.ti_beg < c.ti_end && c.ti_end < c.period &&
           c.tp_beg < c.tp_end && c.tp_end < c.period &&
           c.tobm < c.period;
  endfunction
endpackage

// File: rtl/sync_cfg_shadow.sv
// sync_cfg_shadow: validates config loads, holds pending/active config and moves pending to active on xfer
module sync_cfg_shadow
  import sync_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      cfg_load,
  input  logic      xfer,
  input  sync_cfg_t cfg_in,
  output sync_cfg_t act,
  output logic      act_vld,
  output logic      cfg_err
);
  sync_cfg_t pend;
  logic pend_vld, ok;
  assign ok = cfg_valid(cfg_in);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= '0;
      act <= '0;
      pend_vld <= 1'b0;
      act_vld <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (xfer && pend_vld) begin
        act <= pend;
        act_vld <= 1'b1;
      end
      // a load accepted on a transfer clk stays pending for the next boundary
      pend_vld <= (cfg_load && ok) || (pend_vld && !xfer);
      if (cfg_load) cfg_err <= !ok;
      if (cfg_load && ok) pend <= cfg_in;
    end
endmodule

// File: rtl/sync_pulse_gen.sv
// sync_pulse_gen: frame/cycle tick counters and registered one-clk strobes for the B700 synchroniser
module sync_pulse_gen #(
  parameter int CNT_W = sync_pkg::CNT_W,
  parameter int NCYC_W = sync_pkg::NCYC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [NCYC_W-1:0] cfg_ncyc,
  input  logic [CNT_W-1:0]  cfg_ti_beg,
  input  logic [CNT_W-1:0]  cfg_ti_end,
  input  logic [CNT_W-1:0]  cfg_tp_beg,
  input  logic [CNT_W-1:0]  cfg_tp_end,
  input  logic [CNT_W-1:0]  cfg_tobm,
  output logic              TNO,
  output logic              TNC,
  output logic              TNI,
  output logic              TKI,
  output logic              TNP,
  output logic              TKP,
  output logic              TOBM,
  output logic              busy,
  output logic              cfg_err
);
  import sync_pkg::*;
  state_t state;
  sync_cfg_t act, cfg_in;
  logic act_vld, run, tick_last, cyc_last, frame_end;
  logic [CNT_W-1:0] tick;
  logic [NCYC_W-1:0] cyc;
  assign cfg_in = '{period: cfg_period, ncyc: cfg_ncyc, ti_beg: cfg_ti_beg, ti_end: cfg_ti_end,
                    tp_beg: cfg_tp_beg, tp_end: cfg_tp_end, tobm: cfg_tobm};
  assign run = state == ST_RUN;
  assign tick_last = tick == act.period - 1'b1;
  assign cyc_last = cyc == act.ncyc - 1'b1;
  assign frame_end = run && tick_last && cyc_last;
  assign busy = run;
  sync_cfg_shadow u_shadow (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_load(cfg_load),
    .xfer(!run || frame_end),
    .cfg_in(cfg_in),
    .act(act),
    .act_vld(act_vld),
    .cfg_err(cfg_err)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      tick <= '0;
      cyc <= '0;
      {TNO, TNC, TNI, TKI, TNP, TKP, TOBM} <= '0;
    end else begin
      TNC <= run && tick == '0;
      TNO <= run && tick == '0 && cyc == '0;
      TNI <= run && tick == act.ti_beg;
      TKI <= run && tick == act.ti_end;
      TNP <= run && tick == act.tp_beg;
      TKP <= run && tick == act.tp_end;
      TOBM <= run && tick == act.tobm && cyc_last;
      if (!run) begin
        tick <= '0;
        cyc <= '0;
        if (en && act_vld) state <= ST_RUN;
      end else begin
        tick <= tick_last ? '0 : tick + 1'b1;
        if (tick_last) cyc <= cyc_last ? '0 : cyc + 1'b1;
        if (frame_end && !en) state <= ST_IDLE;
      end
    end
endmodule

// File: tb/tb_sync_pulse_gen.sv
// tb_sync_pulse_gen: frame-position reference model compared every clk, plus literal schedule checks
module tb_sync_pulse_gen;
  logic clk = 0, rst_n = 0, en = 0, cfg_load = 0;
  logic [23:0] cfg_period = 0, cfg_ti_beg = 0, cfg_ti_end = 0, cfg_tp_beg = 0, cfg_tp_end = 0, cfg_tobm = 0;
  logic [7:0] cfg_ncyc = 0;
  logic TNO, TNC, TNI, TKI, TNP, TKP, TOBM, busy, cfg_err;
  always #5 clk = ~clk;
  sync_pulse_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
    .cfg_period(cfg_period), .cfg_ncyc(cfg_ncyc), .cfg_ti_beg(cfg_ti_beg), .cfg_ti_end(cfg_ti_end),
    .cfg_tp_beg(cfg_tp_beg), .cfg_tp_end(cfg_tp_end), .cfg_tobm(cfg_tobm),
    .TNO(TNO), .TNC(TNC), .TNI(TNI), .TKI(TKI), .TNP(TNP), .TKP(TKP), .TOBM(TOBM),
    .busy(busy), .cfg_err(cfg_err)
  );
  int checks = 0, failures = 0;
  function automatic void chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endfunction
  typedef struct {int per, ncyc, tib, tie, tpb, tpe, tobm;} mcfg_t;
  mcfg_t m_pend, m_act, m_in;
  bit m_pvld, m_avld, m_err, m_run, ok, fend, xfer;
  int m_n, tk, cy;
  logic [6:0] exp_str;
  function automatic bit mvalid(mcfg_t c);
    return c.per >= 2 && c.ncyc >= 1 && c.tib < c.tie && c.tie < c.per &&
           c.tpb < c.tpe && c.tpe < c.per && c.tobm < c.per;
  endfunction
  // m_n is the clk position inside the current frame; tick/cycle fall out by division
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend = '{0, 0, 0, 0, 0, 0, 0};
      m_act = m_pend;
      {m_pvld, m_avld, m_err, m_run} = '0;
      m_n = 0;
      exp_str = '0;
    end else begin
      m_in = '{int'(cfg_period), int'(cfg_ncyc), int'(cfg_ti_beg), int'(cfg_ti_end),
               int'(cfg_tp_beg), int'(cfg_tp_end), int'(cfg_tobm)};
      ok = mvalid(m_in);
      tk = m_run ? m_n % m_act.per : -1;
      cy = m_run ? m_n / m_act.per : -1;
      exp_str = m_run ? {tk == 0 && cy == 0, tk == 0, tk == m_act.tib, tk == m_act.tie,
                         tk == m_act.tpb, tk == m_act.tpe, tk == m_act.tobm && cy == m_act.ncyc - 1} : 7'b0;
      fend = m_run && m_n == m_act.per * m_act.ncyc - 1;
      xfer = !m_run || fend;
      if (!m_run) begin
        if (en && m_avld) begin m_run = 1; m_n = 0; end
      end else if (fend) begin
        m_n = 0;
        if (!en) m_run = 0;
      end else m_n++;
      if (xfer && m_pvld) begin m_act = m_pend; m_avld = 1; end
      m_pvld = (cfg_load && ok) || (m_pvld && !xfer);
      if (cfg_load) m_err = !ok;
      if (cfg_load && ok) m_pend = m_in;
    end
    #1;
    chk("strobes", int'({TNO, TNC, TNI, TKI, TNP, TKP, TOBM}), int'(exp_str));
    chk("busy", int'(busy), int'(m_run));
    chk("cfg_err", int'(cfg_err), int'(m_err));
  end
  int rc[9], rf[9];
  task automatic rec(input int n);
    logic [8:0] v;
    for (int j = 0; j < 9; j++) begin rc[j] = 0; rf[j] = -1; end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      v = {TNO & TNC & TNI & TNP & TOBM, busy, TOBM, TKP, TNP, TKI, TNI, TNC, TNO};
      for (int j = 0; j < 9; j++) if (v[j]) begin rc[j]++; if (rf[j] < 0) rf[j] = i; end
    end
  endtask
  task automatic load(input int p, input int nc, input int a, input int b, input int c, input int d, input int o);
    @(negedge clk);
    cfg_period = 24'(p); cfg_ncyc = 8'(nc); cfg_ti_beg = 24'(a); cfg_ti_end = 24'(b);
    cfg_tp_beg = 24'(c); cfg_tp_end = 24'(d); cfg_tobm = 24'(o); cfg_load = 1;
    @(negedge clk);
    cfg_load = 0;
  endtask
  task automatic wait_tno();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (TNO) return;
    end
    chk("wait_tno_timeout", 0, 1);
  endtask
  int r;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outputs", int'({TNO, TNC, TNI, TKI, TNP, TKP, TOBM, busy, cfg_err}), 0);
    rst_n = 1;
    // basic schedule: period 10, 3 cycles
    load(10, 3, 2, 5, 6, 9, 8);
    en = 1;
    rec(95);
    chk("t1_first_tno", rf[0], 2);
    chk("t1_first_tni", rf[2], 4);
    chk("t1_first_tki", rf[3], 7);
    chk("t1_first_tnp", rf[4], 8);
    chk("t1_first_tkp", rf[5], 11);
    chk("t1_first_tobm", rf[6], 30);
    chk("t1_cnt_tno", rc[0], 4);
    chk("t1_cnt_tnc", rc[1], 10);
    chk("t1_cnt_tobm", rc[6], 3);
    // rejected load, then accepted load
    load(10, 3, 5, 5, 6, 9, 8);
    chk("t2_err_set", int'(cfg_err), 1);
    rec(10);
    chk("t2_tnc_kept", rc[1], 1);
    load(10, 3, 2, 5, 6, 9, 8);
    chk("t2_err_clr", int'(cfg_err), 0);
    // mid-frame period change waits for the frame boundary
    wait_tno();
    load(4, 3, 1, 2, 1, 3, 3);
    rec(60);
    chk("t3_first_tno", rf[0], 28);
    chk("t3_cnt_tno", rc[0], 3);
    chk("t3_cnt_tnc", rc[1], 10);
    // en dropped at tick 3 of cycle 0
    wait_tno();
    @(posedge clk); @(posedge clk);
    @(negedge clk); en = 0;
    rec(20);
    chk("t4_cnt_tno", rc[0], 0);
    chk("t4_cnt_tnc", rc[1], 2);
    chk("t4_cnt_tobm", rc[6], 1);
    chk("t4_busy_clks", rc[7], 8);
    // async reset mid-frame
    @(negedge clk); en = 1;
    repeat (7) @(negedge clk);
    rst_n = 0;
    #1 chk("t5_rst_now", int'({TNO, TNC, TNI, TKI, TNP, TKP, TOBM, busy}), 0);
    @(negedge clk); @(negedge clk); rst_n = 1;
    rec(20);
    chk("t5_no_tnc", rc[1], 0);
    chk("t5_no_busy", rc[7], 0);
    // minimal frame: all begin strobes coincide
    load(2, 1, 0, 1, 0, 1, 0);
    rec(20);
    chk("t6_cnt_coinc", rc[8], 9);
    chk("t6_cnt_tki", rc[3], 9);
    chk("t6_first_tki", rf[3], 3);
    chk("t6_cnt_tkp", rc[5], 9);
    // randomized traffic
    for (int it = 0; it < 500; it++) begin
      @(negedge clk);
      r = $urandom_range(99);
      if (r < 3) begin
        rst_n = 0; @(negedge clk); rst_n = 1;
      end else if (r < 25) begin
        int a, c;
        a = $urandom_range(0, 5); c = $urandom_range(0, 5);
        load($urandom_range(1, 9), $urandom_range(0, 4), a, a + $urandom_range(0, 3),
             c, c + $urandom_range(0, 3), $urandom_range(0, 8));
      end else if (r < 37) en = ~en;
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    en = 0;
    repeat (60) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
